// File: rtl/iter_comparator.sv
// Iterative MSB-first magnitude comparator. Examines DIGIT bits per cycle,
// stops at the first unequal digit and drives a one-hot less/equal/greater
// result to the RGB LED, which holds until the next compare completes.
module iter_comparator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               sgn,
  input  logic [WIDTH-1:0]                   A,
  input  logic [WIDTH-1:0]                   B,
  output logic                               busy,
  output logic                               done,
  output logic [0:2]                         RGB,
  output logic [$clog2(WIDTH/DIGIT):0]       cycles
);

  localparam int unsigned NDig = WIDTH / DIGIT;
  localparam int unsigned CW   = $clog2(NDig) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_idx;
  logic [0:2]       r_rgb;
  logic [CW-1:0]    r_cycles;

  logic [DIGIT-1:0] w_da;
  logic [DIGIT-1:0] w_db;
  logic [WIDTH-1:0] w_msb;

  // The operands are shifted left each RUN cycle, so the digit under test
  // always sits at the top of the captured registers.
  assign w_da  = r_a[WIDTH-1 -: DIGIT];
  assign w_db  = r_b[WIDTH-1 -: DIGIT];
  // Flipping both sign bits maps two's-complement onto offset binary, which
  // then orders correctly as unsigned. It is applied once, at capture.
  assign w_msb = {1'b1, {(WIDTH-1){1'b0}}};

  assign busy   = (r_state == StRun);
  assign done   = (r_state == StDone);
  assign RGB    = r_rgb;
  assign cycles = r_cycles;

  // Control FSM together with the operand, index and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_rgb    <= 3'b000;
      r_cycles <= '0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_a     <= sgn ? (A ^ w_msb) : A;
            r_b     <= sgn ? (B ^ w_msb) : B;
            r_idx   <= '0;
            r_state <= StRun;
          end else begin
            r_state <= StIdle;
          end
        end
        StRun: begin
          if (w_da != w_db) begin
            r_rgb    <= (w_da < w_db) ? 3'b100 : 3'b001;
            r_cycles <= r_idx + CW'(1);
            r_state  <= StDone;
          end else if (r_idx == CW'(NDig - 1)) begin
            r_rgb    <= 3'b010;
            r_cycles <= CW'(NDig);
            r_state  <= StDone;
          end else begin
            r_idx <= r_idx + CW'(1);
            r_a   <= r_a << DIGIT;
            r_b   <= r_b << DIGIT;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_comparator.sv
// Self-checking bench for iter_comparator (WIDTH=8, DIGIT=2): directed cases
// plus random compares against an arithmetic reference model.
module tb_iter_comparator;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIGIT = 2;
  localparam int unsigned NDIG  = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             sgn = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             busy;
  logic             done;
  logic [0:2]       RGB;
  logic [$clog2(NDIG):0] cycles;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] prev_rgb = 3'b000;

  iter_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sgn    (sgn),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .RGB    (RGB),
    .cycles (cycles)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: result from integer comparison, digit count from the first
  // nonzero digit of A^B (sign handling never changes which bits differ).
  function automatic logic [2:0] model_rgb(input logic [7:0] a, input logic [7:0] b,
                                           input logic s);
    int va, vb;
    va = s ? int'($signed(a)) : int'(a);
    vb = s ? int'($signed(b)) : int'(b);
    if (va < vb) return 3'b100;
    if (va > vb) return 3'b001;
    return 3'b010;
  endfunction

  function automatic int model_k(input logic [7:0] a, input logic [7:0] b);
    int x;
    x = int'(a ^ b);
    for (int i = 0; i < int'(NDIG); i++) begin
      if (((x >> (WIDTH - DIGIT * (i + 1))) & ((1 << DIGIT) - 1)) != 0) return i + 1;
    end
    return NDIG;
  endfunction

  task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [2:0] er;
    int         ek;
    int         n;
    er = model_rgb(a, b, s);
    ek = model_k(a, b);
    @(negedge clk);
    A = a; B = b; sgn = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = WIDTH'($urandom); B = WIDTH'($urandom); sgn = 1'($urandom);
    n = 0;
    while (!done && n < 20) begin
      check_eq("busy_run", 32'(busy), 32'd1);
      check_eq("rgb_hold", 32'(RGB), 32'(prev_rgb));
      @(negedge clk);
      n++;
    end
    check_eq("latency", n, ek);
    check_eq("done", 32'(done), 32'd1);
    check_eq("busy_done", 32'(busy), 32'd0);
    check_eq("rgb", 32'(RGB), 32'(er));
    check_eq("cycles", 32'(cycles), ek);
    prev_rgb = er;
    @(negedge clk);
    check_eq("done_pulse", 32'(done), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int ndone;
    int first_i, second_i;
    logic [2:0] first_rgb;

    // Reset with start asserted.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; A = 8'h12; B = 8'h34;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_rgb", 32'(RGB), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_cycles", 32'(cycles), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_eq("rst_nostart", 32'(busy), 32'd0);

    // Directed cases.
    run_cmp(8'h5A, 8'h5A, 1'b0);
    run_cmp(8'hC0, 8'h3F, 1'b0);
    run_cmp(8'hC0, 8'h3F, 1'b1);
    run_cmp(8'h12, 8'h13, 1'b0);
    run_cmp(8'h12, 8'h13, 1'b1);

    // Start re-asserted while busy is ignored.
    @(negedge clk);
    A = 8'h5A; B = 8'h5A; sgn = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 8'h00; B = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check_eq("busy_start_ndone", ndone, 1);
    check_eq("busy_start_rgb", 32'(RGB), 32'(3'b010));
    check_eq("busy_start_cyc", 32'(cycles), 32'd4);
    prev_rgb = 3'b010;

    // Start held high: second compare accepted in the done cycle.
    A = 8'h12; B = 8'h13; sgn = 1'b0; start = 1'b1;
    ndone = 0; first_i = -1; second_i = -1; first_rgb = 3'b000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        A = 8'h01; B = 8'h00;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          first_i = i; first_rgb = RGB;
        end else if (ndone == 2) begin
          second_i = i;
          check_eq("held_rgb2", 32'(RGB), 32'(3'b001));
          check_eq("held_cyc2", 32'(cycles), 32'd4);
        end
      end else if (ndone == 1 && busy) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq("held_ndone", ndone, 2);
    check_eq("held_i1", first_i, 4);
    check_eq("held_rgb1", 32'(first_rgb), 32'(3'b100));
    check_eq("held_i2", second_i, 9);
    prev_rgb = 3'b001;

    // Reset in the middle of a compare.
    @(negedge clk);
    A = 8'h00; B = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_rgb", 32'(RGB), 32'd0);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_eq("abort_nodone", ndone, 0);
    prev_rgb = 3'b000;
    run_cmp(8'h80, 8'h7F, 1'b1);

    // Random compares, with forced-equal prefixes to exercise later digits.
    for (int t = 0; t < 40; t++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (t % 3 == 0) rb = (ra & 8'hF0) | (rb & 8'h0F);
      if (t % 7 == 0) rb = ra;
      run_cmp(ra, rb, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iter_comparator.md
Name: iter_comparator

Overview:
- Parametrised, clocked successor to the team's 2-bit RGB magnitude comparator.
- Compares two WIDTH-bit operands iteratively, MSB first, DIGIT bits per cycle, and exits early on the first unequal digit.
- Supports an unsigned or two's-complement mode and a start/busy/done handshake.
- Drives the same one-hot RGB indication (less / equal / greater) to the board LED, holding the last result until the next compare completes.

Parameters:
- WIDTH, 8: operand width in bits; must be a multiple of DIGIT, minimum 2.
- DIGIT, 2: bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a compare; accepted only when busy=0.
- sgn  in  1  sampled with start; 1 = two's-complement compare, 0 = unsigned.
- A  in  WIDTH  operand A, bit WIDTH-1 is MSB; sampled on accepted start.
- B  in  WIDTH  operand B, same format; sampled on accepted start.
- busy  out  1  compare in progress.
- done  out  1  one-cycle pulse when a result is registered.
- RGB  out  3, declared [0:2]  one-hot result: RGB[0]=A<B (red), RGB[1]=A==B (green), RGB[2]=A>B (blue).
- cycles  out  clog2(WIDTH/DIGIT)+1  number of digits examined for the last result.

Behaviour:
- Reset (rst=1 at clock edge, any state):
  - FSM→IDLE; busy=0, done=0, RGB=000 (LED off), cycles=0.
  - Captured operands and digit counter are cleared.
  - Reset overrides start in the same cycle.
  - Reset mid-compare aborts it; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start=1 → RUN. Capture A, B and sgn; digit index = 0 (MSB digit); busy=1 from next cycle.
  - RUN, per edge: compare digit i, i.e. bits [WIDTH-1-i*DIGIT -: DIGIT], as unsigned DIGIT-bit values.
    - Signed mode only: for digit 0, invert operand MSBs before the compare (offset-binary trick).
    - Digits unequal: register the less/greater result into RGB, cycles=i+1, → DONE.
    - Digits equal and i = WIDTH/DIGIT-1: RGB=010, cycles=WIDTH/DIGIT, → DONE.
    - Otherwise: i+1, stay in RUN.
  - DONE: done=1 and busy=0 for exactly this cycle; then → IDLE unless start=1, which is accepted as from IDLE.
- Latency: if start is sampled at edge E0 and the deciding digit is the k-th digit (k=1..WIDTH/DIGIT), RGB/cycles update at edge Ek and done is high in the cycle after Ek. busy is high from after E0 to Ek.
- RGB holds the previous result throughout RUN; it only changes at the deciding edge. RGB is always one-hot except 000 after reset.
- start while busy=1 is ignored (not queued). A, B and sgn changes during RUN have no effect.
- Back-to-back operation: start held continuously gives one compare per (k+1) cycles; the done cycle doubles as the accept cycle.
- Degenerate DIGIT=WIDTH: single RUN cycle, cycles always 1.

Test Plan:
- Reset: assert rst 2 cycles with start=1 → RGB=000, busy=0, done=0, cycles=0; no compare starts.
- Equal, WIDTH=8/DIGIT=2: A=0x5A, B=0x5A, sgn=0, pulse start → busy for 4 cycles, single done pulse, RGB=010, cycles=4.
- Early exit and mode: A=0xC0, B=0x3F.
  - sgn=0 → done after 1 digit, RGB=001 (A>B), cycles=1.
  - Repeat with sgn=1 → RGB=100 (−64<63), cycles=1.
- Last-digit decision: A=0x12, B=0x13, sgn=0 → RGB unchanged during busy, then RGB=100, cycles=4. Repeat with sgn=1 → identical result.
- Handshake:
  - start re-asserted while busy → ignored; only one done pulse.
  - start held high → new compare accepted in the done cycle; operands 0x01 vs 0x00 then give RGB=001 after 4 more cycles.
- Reset mid-op: start A=0x00, B=0x00, assert rst after 2 RUN cycles → no done pulse, RGB=000, busy=0 next cycle. A subsequent compare completes normally.
